// File: rtl/i2c_reg_target.sv
// I2C target exposing a 2**REG_AW byte register file through an auto-incrementing pointer.
// Bus conditions are seen 3 clk after the pad edge; sda_oe changes 1 clk after a detected SCL fall.
// No clock stretching: every byte is ACKed unconditionally and the local read port never stalls.
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter int         REG_AW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              wr_stb,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_stb,
  output logic [REG_AW-1:0] rd_addr,
  input  logic [REG_AW-1:0] loc_raddr,
  output logic [7:0]        loc_rdata,
  output logic              busy
);

  localparam int NREG = 1 << REG_AW;
  localparam logic [REG_AW-1:0] PTR_ONE = {{(REG_AW-1){1'b0}}, 1'b1};

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_WAIT      = 4'd9;

  // synchronizer and edge-detect taps
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  logic [3:0]        state;
  logic [3:0]        bitcnt;
  logic [6:0]        shreg;
  logic [7:0]        txreg;
  logic              ack_ph;
  logic              rw_bit;
  logic [REG_AW-1:0] ptr;
  logic [7:0]        regs [NREG];

  logic       scl_rise, scl_fall;
  logic       start_det, stop_det;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       addr_hit;

  // Two-flop synchronizers plus one delay stage; idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  // SDA moving while SCL is held high is always a bus condition, never data.
  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  // The byte being completed includes the bit sampled on this rise.
  assign rx_byte   = {shreg, sda_s2};
  assign byte_done = scl_rise && (bitcnt == 4'd7);
  assign addr_hit  = (rx_byte[7:1] == DEV_ADDR);

  // Protocol sequencer: receives bytes, drives ACKs and read data, owns the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      bitcnt  <= 4'd0;
      shreg   <= 7'd0;
      txreg   <= 8'd0;
      ack_ph  <= 1'b0;
      rw_bit  <= 1'b0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'd0;
      rd_stb  <= 1'b0;
      rd_addr <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= 8'd0;
    end else begin
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
      if (start_det) begin
        // Covers repeated START as well; any partial byte is dropped.
        state  <= S_ADDR;
        bitcnt <= 4'd0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (stop_det) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            sda_oe <= 1'b0;
          end

          S_ADDR: begin
            if (byte_done) begin
              bitcnt <= 4'd0;
              ack_ph <= 1'b0;
              rw_bit <= rx_byte[0];
              if (addr_hit) begin
                busy  <= 1'b1;
                state <= S_ADDR_ACK;
                if (rx_byte[0]) begin
                  // Load now so the first bit is ready at the ACK release fall.
                  txreg   <= regs[ptr];
                  rd_stb  <= 1'b1;
                  rd_addr <= ptr;
                end
              end else begin
                state <= S_WAIT;
              end
            end else if (scl_rise) begin
              shreg  <= rx_byte[6:0];
              bitcnt <= bitcnt + 4'd1;
            end
          end

          S_PTR: begin
            if (byte_done) begin
              bitcnt <= 4'd0;
              ack_ph <= 1'b0;
              ptr    <= rx_byte[REG_AW-1:0];
              state  <= S_PTR_ACK;
            end else if (scl_rise) begin
              shreg  <= rx_byte[6:0];
              bitcnt <= bitcnt + 4'd1;
            end
          end

          S_WDATA: begin
            if (byte_done) begin
              bitcnt    <= 4'd0;
              ack_ph    <= 1'b0;
              regs[ptr] <= rx_byte;
              wr_stb    <= 1'b1;
              wr_addr   <= ptr;
              wr_data   <= rx_byte;
              ptr       <= ptr + PTR_ONE;
              state     <= S_WDATA_ACK;
            end else if (scl_rise) begin
              shreg  <= rx_byte[6:0];
              bitcnt <= bitcnt + 4'd1;
            end
          end

          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            // First fall starts the ACK slot, second fall ends it.
            if (scl_fall) begin
              if (!ack_ph) begin
                sda_oe <= 1'b1;
                ack_ph <= 1'b1;
              end else begin
                ack_ph <= 1'b0;
                bitcnt <= 4'd0;
                sda_oe <= 1'b0;
                if (state == S_ADDR_ACK && rw_bit) begin
                  sda_oe <= ~txreg[7];
                  txreg  <= {txreg[6:0], 1'b0};
                  bitcnt <= 4'd1;
                  state  <= S_RDATA;
                end else if (state == S_ADDR_ACK) begin
                  state <= S_PTR;
                end else begin
                  state <= S_WDATA;
                end
              end
            end
          end

          S_RDATA: begin
            // bitcnt counts bits already placed on the bus.
            if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_oe <= 1'b0;
                ptr    <= ptr + PTR_ONE;
                ack_ph <= 1'b0;
                state  <= S_RDATA_ACK;
              end else begin
                sda_oe <= ~txreg[7];
                txreg  <= {txreg[6:0], 1'b0};
                bitcnt <= bitcnt + 4'd1;
              end
            end
          end

          S_RDATA_ACK: begin
            if (scl_rise && !ack_ph) begin
              if (!sda_s2) begin
                txreg   <= regs[ptr];
                rd_stb  <= 1'b1;
                rd_addr <= ptr;
                ack_ph  <= 1'b1;
              end else begin
                state <= S_WAIT;
              end
            end else if (scl_fall && ack_ph) begin
              sda_oe <= ~txreg[7];
              txreg  <= {txreg[6:0], 1'b0};
              bitcnt <= 4'd1;
              ack_ph <= 1'b0;
              state  <= S_RDATA;
            end
          end

          S_WAIT: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= S_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  // Registered local read port; a bus write shows up one cycle after wr_stb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) loc_rdata <= 8'd0;
    else     loc_rdata <= regs[loc_raddr];
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: an I2C master model drives transactions while a
// transaction-level register/pointer model predicts ACKs, strobes, read bytes and loc_rdata.
module tb_i2c_reg_target;

  localparam int Q = 8;
  localparam int H = 12;

  localparam int PH_ADDR = 0;
  localparam int PH_PTR  = 1;
  localparam int PH_DATA = 2;
  localparam int PH_RD   = 3;
  localparam int PH_IGN  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_i;
  logic       sda_m;
  logic       sda_i;
  logic       sda_oe;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_stb;
  logic [3:0] rd_addr;
  logic [3:0] loc_raddr;
  logic [7:0] loc_rdata;
  logic       busy;

  // Open-drain bus: either side can pull the line low.
  assign sda_i = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_reg_target #(.DEV_ADDR(7'h48), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_stb(rd_stb), .rd_addr(rd_addr),
    .loc_raddr(loc_raddr), .loc_rdata(loc_rdata), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model of the target.
  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] mregs [16];
  logic [3:0] mptr;
  int         m_phase;
  bit         quiet;
  wr_t        exp_wr [$];
  logic [3:0] exp_rd [$];
  wr_t        e_wr;
  logic [3:0] e_rd;
  logic [7:0] exp_loc;
  bit         loc_vld = 1'b0;

  // Per-cycle compare of strobes, local read port and SDA silence against the model.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mregs[i] = 8'd0;
      exp_wr.delete();
      exp_rd.delete();
      loc_vld = 1'b0;
    end else begin
      if (loc_vld) chk("loc_rdata", loc_rdata, exp_loc);
      if (wr_stb) begin
        if (exp_wr.size() == 0) chk("wr_stb_unexpected", wr_stb, 0);
        else begin
          e_wr = exp_wr.pop_front();
          chk("wr_addr", wr_addr, e_wr.a);
          chk("wr_data", wr_data, e_wr.d);
          mregs[e_wr.a] = e_wr.d;
        end
      end
      if (rd_stb) begin
        if (exp_rd.size() == 0) chk("rd_stb_unexpected", rd_stb, 0);
        else begin
          e_rd = exp_rd.pop_front();
          chk("rd_addr", rd_addr, e_rd);
        end
      end
      if (quiet) chk("sda_oe_quiet", sda_oe, 0);
      exp_loc = mregs[loc_raddr];
      loc_vld = 1'b1;
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic b);
    sda_m = b;
    wclk(Q);
    scl_i = 1'b1;
    wclk(H);
    scl_i = 1'b0;
    wclk(Q);
  endtask

  task automatic bit_in(output logic b);
    sda_m = 1'b1;
    wclk(Q);
    scl_i = 1'b1;
    wclk(H / 2);
    b = sda_i;
    wclk(H / 2);
    scl_i = 1'b0;
    wclk(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wclk(Q);
    scl_i = 1'b1;
    wclk(H / 2);
    sda_m = 1'b0;
    wclk(H / 2);
    scl_i = 1'b0;
    wclk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wclk(Q);
    scl_i = 1'b1;
    wclk(H / 2);
    sda_m = 1'b1;
    wclk(H);
  endtask

  task automatic m_start();
    bus_start();
    m_phase = PH_ADDR;
    quiet   = 1'b0;
  endtask

  task automatic m_stop();
    bus_stop();
    m_phase = PH_IGN;
    quiet   = 1'b1;
  endtask

  // Master writes one byte; the model decides what the target must do with it.
  task automatic m_send(input logic [7:0] b);
    logic exp_ack;
    logic ack;
    exp_ack = 1'b0;
    case (m_phase)
      PH_ADDR: begin
        if (b[7:1] == 7'h48) begin
          if (b[0]) begin
            exp_rd.push_back(mptr);
            m_phase = PH_RD;
          end else begin
            m_phase = PH_PTR;
          end
        end else begin
          exp_ack = 1'b1;
          m_phase = PH_IGN;
          quiet   = 1'b1;
        end
      end
      PH_PTR: begin
        mptr    = b[3:0];
        m_phase = PH_DATA;
      end
      PH_DATA: begin
        exp_wr.push_back(wr_t'{a: mptr, d: b});
        mptr = mptr + 4'd1;
      end
      default: exp_ack = 1'b1;
    endcase
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_in(ack);
    chk("ack", ack, exp_ack);
  endtask

  // Master reads one byte and then ACKs (mack=0) or NACKs (mack=1).
  task automatic m_recv(input logic mack, output logic [7:0] d);
    logic [7:0] e;
    logic       bb;
    e    = mregs[mptr];
    mptr = mptr + 4'd1;
    for (int i = 7; i >= 0; i--) begin
      bit_in(bb);
      d[i] = bb;
    end
    chk("rd_byte", d, e);
    if (!mack) exp_rd.push_back(mptr);
    else       m_phase = PH_IGN;
    bit_out(mack);
    if (mack) quiet = 1'b1;
  endtask

  task automatic check_loc(input logic [3:0] a, input logic [7:0] exp, input string nm);
    loc_raddr = a;
    wclk(3);
    chk(nm, loc_rdata, exp);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       bb;
    scl_i     = 1'b1;
    sda_m     = 1'b1;
    loc_raddr = 4'd0;
    rst       = 1'b1;
    quiet     = 1'b1;
    m_phase   = PH_IGN;
    mptr      = 4'd0;
    wclk(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_rd_stb", rd_stb, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_loc_rdata", loc_rdata, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    wclk(5);

    // Write burst: ptr 3, A5 5A
    m_start();
    m_send(8'h90);
    chk("busy_after_match", busy, 1);
    m_send(8'h03);
    m_send(8'hA5);
    m_send(8'h5A);
    m_stop();
    chk("busy_after_stop", busy, 0);
    check_loc(4'd3, 8'hA5, "burst_reg3");
    check_loc(4'd4, 8'h5A, "burst_reg4");
    chk("model_ptr_after_burst", mptr, 5);

    // Read at the current pointer (5) without writing a pointer
    m_start();
    m_send(8'h91);
    m_recv(1'b1, d);
    chk("read_at_ptr5", d, 8'h00);
    m_stop();

    // Pointer write, repeated START, two-byte read
    m_start();
    m_send(8'h90);
    m_send(8'h03);
    m_start();
    m_send(8'h91);
    m_recv(1'b0, d);
    chk("sr_read_byte1", d, 8'hA5);
    m_recv(1'b1, d);
    chk("sr_read_byte2", d, 8'h5A);
    chk("sda_oe_after_nack", sda_oe, 0);
    m_stop();
    chk("busy_after_read_stop", busy, 0);

    // Seed regs 1 and 2
    m_start();
    m_send(8'h90);
    m_send(8'h01);
    m_send(8'h3C);
    m_send(8'h2B);
    m_stop();

    // Address mismatch
    m_start();
    m_send(8'h92);
    chk("busy_mismatch", busy, 0);
    m_send(8'h00);
    m_send(8'hFF);
    m_stop();
    check_loc(4'd3, 8'hA5, "mismatch_reg3");
    check_loc(4'd0, 8'h00, "mismatch_reg0");

    // Pointer wrap
    m_start();
    m_send(8'h90);
    m_send(8'h0F);
    m_send(8'h11);
    m_send(8'h22);
    m_stop();
    check_loc(4'd15, 8'h11, "wrap_reg15");
    check_loc(4'd0, 8'h22, "wrap_reg0");
    m_start();
    m_send(8'h91);
    m_recv(1'b1, d);
    chk("wrap_ptr1_read", d, 8'h3C);
    m_stop();

    // Upper pointer bits ignored
    m_start();
    m_send(8'h90);
    m_send(8'hF7);
    m_send(8'hC7);
    m_stop();
    check_loc(4'd7, 8'hC7, "ptr_f7_reg7");

    // Abort after 5 data bits
    m_start();
    m_send(8'h90);
    m_send(8'h02);
    for (int i = 0; i < 5; i++) bit_out(1'b1);
    m_stop();
    check_loc(4'd2, 8'h2B, "abort_reg2_kept");
    m_start();
    m_send(8'h91);
    m_recv(1'b1, d);
    chk("abort_ptr_unchanged", d, 8'h2B);
    m_stop();
    m_start();
    m_send(8'h90);
    m_send(8'h02);
    m_send(8'hE1);
    m_stop();
    check_loc(4'd2, 8'hE1, "after_abort_write");

    // Reset while the target drives a 0 bit (A5: second bit is 0)
    m_start();
    m_send(8'h90);
    m_send(8'h03);
    m_start();
    m_send(8'h91);
    bit_in(bb);
    chk("rst_read_bit1", bb, 1);
    sda_m = 1'b1;
    wclk(Q);
    chk("rst_read_drive0", sda_oe, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_sda_oe", sda_oe, 0);
    chk("rst_async_busy", busy, 0);
    m_phase = PH_IGN;
    mptr    = 4'd0;
    quiet   = 1'b1;
    wclk(4);
    rst = 1'b0;
    wclk(2);
    scl_i = 1'b1;
    wclk(H);
    scl_i = 1'b0;
    wclk(Q);
    m_stop();
    check_loc(4'd3, 8'h00, "rst_cleared_reg3");
    check_loc(4'd1, 8'h00, "rst_cleared_reg1");

    // Normal write after reset
    m_start();
    m_send(8'h90);
    m_send(8'h06);
    m_send(8'h66);
    m_stop();
    check_loc(4'd6, 8'h66, "post_rst_write");

    wclk(10);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
